// File: rtl/multicomp_pkg.sv
// ---------------------------------------------------------------------------
// multicomp_pkg
// Purpose : Shared types and default timing constants for the MultiComp core
//           sequencer (core select encodings, sequencer states, cycle counts).
// Ports   : none (package).
// ---------------------------------------------------------------------------
package multicomp_pkg;

  // Selectable computer cores; the encoding is the value driven on core_sel.
  typedef enum logic [1:0] {
    CPU_Z80_CPM   = 2'd0,
    CPU_Z80_BASIC = 2'd1,
    CPU_6502      = 2'd2,
    CPU_6809      = 2'd3
  } cpu_type_e;

  typedef enum logic [1:0] {
    ST_HOLD,
    ST_SETTLE,
    ST_RUN,
    ST_DRAIN
  } seq_state_e;

  // Default timing, in clk_sys cycles at 50 MHz.
  localparam int unsigned DEF_RST_HOLD      = 1024;
  localparam int unsigned DEF_SER_INIT      = 50000;    // 1 ms
  localparam int unsigned DEF_TX_IDLE       = 230000;   // >= one char at 2400 baud
  localparam int unsigned DEF_DRAIN_TIMEOUT = 5000000;

endpackage

// File: rtl/tx_idle_detector.sv
// ---------------------------------------------------------------------------
// tx_idle_detector
// Purpose : While i_active is high, measures how long the selected core's TXD
//           has been continuously at mark and how long the drain has lasted.
//           o_drain_done flags the cycle in which either limit is reached.
// Ports   : clk_sys      in  system clock
//           reset        in  synchronous, active-high
//           i_active     in  high while the sequencer is draining
//           i_serial_tx  in  TXD of the currently selected core
//           o_drain_done out this drain cycle reaches TX_IDLE or DRAIN_TIMEOUT
// ---------------------------------------------------------------------------
module tx_idle_detector
  import multicomp_pkg::*;
#(
  parameter int unsigned TX_IDLE       = DEF_TX_IDLE,
  parameter int unsigned DRAIN_TIMEOUT = DEF_DRAIN_TIMEOUT
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic i_active,
  input  logic i_serial_tx,
  output logic o_drain_done
);

  localparam int unsigned IDLE_W = $clog2(TX_IDLE + 1);
  localparam int unsigned TMO_W  = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TX_IDLE);
  localparam logic [TMO_W-1:0]  TMO_MAX  = TMO_W'(DRAIN_TIMEOUT);

  logic [IDLE_W-1:0] r_idle_cnt;
  logic [IDLE_W-1:0] w_idle_cnt_next;
  logic [TMO_W-1:0]  r_tmo_cnt;
  logic [TMO_W-1:0]  w_tmo_cnt_next;

  // Both counters saturate at their limit so a stalled exit can never wrap.
  always_comb begin
    w_idle_cnt_next = r_idle_cnt;
    if (!i_serial_tx) begin
      w_idle_cnt_next = '0;
    end else if (r_idle_cnt != IDLE_MAX) begin
      w_idle_cnt_next = r_idle_cnt + 1'b1;
    end
    w_tmo_cnt_next = r_tmo_cnt;
    if (r_tmo_cnt != TMO_MAX) begin
      w_tmo_cnt_next = r_tmo_cnt + 1'b1;
    end
  end

  // Done is judged on the count that includes the current cycle, so a drain
  // with a permanently idle line lasts exactly TX_IDLE cycles.
  assign o_drain_done = i_active &&
                        ((w_idle_cnt_next == IDLE_MAX) || (w_tmo_cnt_next == TMO_MAX));

  // Counters are only meaningful inside a drain; they restart at 0 on every entry.
  always_ff @(posedge clk_sys) begin
    if (reset || !i_active) begin
      r_idle_cnt <= '0;
      r_tmo_cnt  <= '0;
    end else begin
      r_idle_cnt <= w_idle_cnt_next;
      r_tmo_cnt  <= w_tmo_cnt_next;
    end
  end

endmodule

// File: rtl/multicomp_core_sequencer.sv
// ---------------------------------------------------------------------------
// multicomp_core_sequencer
// Purpose : Switches the active MultiComp core and serial configuration
//           safely: drains TXD, holds cores in reset when the core changes,
//           releases the selected core and holds off flow control while the
//           serial path settles.
// Ports   : clk_sys          in  system clock
//           reset            in  synchronous, active-high
//           i_cpu_type_req   in  [1:0] requested core (cpu_type_e)
//           i_port_sel_req   in  requested port (0 console UART, 1 user IO)
//           i_flow_en_req    in  requested RTS/CTS enable
//           i_serial_tx_in   in  TXD of the currently selected core
//           o_core_sel       out [1:0] applied core select
//           o_core_rst_n     out [3:0] per-core run enable, one-hot or zero
//           o_port_sel       out applied port select
//           o_flow_en        out applied flow-control enable
//           o_tx_gate        out 1 forces TXD/RTS to mark/deasserted
//           o_cts_en         out CTS path enable
//           o_busy           out high in every state except RUN
// ---------------------------------------------------------------------------
module multicomp_core_sequencer
  import multicomp_pkg::*;
#(
  parameter int unsigned RST_HOLD      = DEF_RST_HOLD,
  parameter int unsigned SER_INIT      = DEF_SER_INIT,
  parameter int unsigned TX_IDLE       = DEF_TX_IDLE,
  parameter int unsigned DRAIN_TIMEOUT = DEF_DRAIN_TIMEOUT
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic [1:0] i_cpu_type_req,
  input  logic       i_port_sel_req,
  input  logic       i_flow_en_req,
  input  logic       i_serial_tx_in,
  output logic [1:0] o_core_sel,
  output logic [3:0] o_core_rst_n,
  output logic       o_port_sel,
  output logic       o_flow_en,
  output logic       o_tx_gate,
  output logic       o_cts_en,
  output logic       o_busy
);

  // One counter serves both HOLD and SETTLE; it restarts on every state change.
  localparam int unsigned CNT_TOP = (RST_HOLD > SER_INIT) ? RST_HOLD : SER_INIT;
  localparam int unsigned CNT_W   = $clog2(CNT_TOP + 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(CNT_TOP);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RST_HOLD - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SER_INIT - 1);

  seq_state_e       r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  cpu_type_e        r_core_sel, w_core_sel_next;
  logic             r_port_sel, w_port_sel_next;
  logic             r_flow_en, w_flow_en_next;
  logic [3:0]       r_core_rst_n, w_core_rst_n_next;
  logic             r_tx_gate, w_tx_gate_next;
  logic             r_cts_en, w_cts_en_next;
  logic             r_busy, w_busy_next;

  logic             w_drain_active;
  logic             w_drain_done;
  logic             w_core_differs;
  logic             w_serial_differs;
  logic [1:0]       w_sel_bits_next;
  logic [3:0]       w_sel_onehot_next;

  assign w_drain_active   = (r_state == ST_DRAIN);
  assign w_core_differs   = (cpu_type_e'(i_cpu_type_req) != r_core_sel);
  assign w_serial_differs = (i_port_sel_req != r_port_sel) || (i_flow_en_req != r_flow_en);

  tx_idle_detector #(
    .TX_IDLE       (TX_IDLE),
    .DRAIN_TIMEOUT (DRAIN_TIMEOUT)
  ) u_tx_idle_detector (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .i_active     (w_drain_active),
    .i_serial_tx  (i_serial_tx_in),
    .o_drain_done (w_drain_done)
  );

  // State register; outputs are registered alongside so they line up with state.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state      <= ST_HOLD;
      r_cnt        <= '0;
      r_core_sel   <= CPU_Z80_CPM;
      r_port_sel   <= 1'b0;
      r_flow_en    <= 1'b0;
      r_core_rst_n <= 4'b0000;
      r_tx_gate    <= 1'b1;
      r_cts_en     <= 1'b0;
      r_busy       <= 1'b1;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_core_sel   <= w_core_sel_next;
      r_port_sel   <= w_port_sel_next;
      r_flow_en    <= w_flow_en_next;
      r_core_rst_n <= w_core_rst_n_next;
      r_tx_gate    <= w_tx_gate_next;
      r_cts_en     <= w_cts_en_next;
      r_busy       <= w_busy_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = '0;
    w_core_sel_next = r_core_sel;
    w_port_sel_next = r_port_sel;
    w_flow_en_next  = r_flow_en;
    case (r_state)
      ST_HOLD: begin
        // All cores are in reset, so the selection can follow the request freely.
        w_core_sel_next = cpu_type_e'(i_cpu_type_req);
        w_port_sel_next = i_port_sel_req;
        w_flow_en_next  = i_flow_en_req;
        w_cnt_next      = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
        if (r_cnt == HOLD_LAST) begin
          w_state_next = ST_SETTLE;
          w_cnt_next   = '0;
        end
      end
      ST_SETTLE: begin
        w_cnt_next = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
        if (r_cnt == SETTLE_LAST) begin
          w_state_next = ST_RUN;
          w_cnt_next   = '0;
        end
      end
      ST_RUN: begin
        if (w_core_differs || w_serial_differs) begin
          w_state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Requests are judged at exit so a reverted request costs no reset.
        if (w_drain_done) begin
          if (w_core_differs) begin
            w_state_next = ST_HOLD;
          end else if (w_serial_differs) begin
            w_port_sel_next = i_port_sel_req;
            w_flow_en_next  = i_flow_en_req;
            w_state_next    = ST_SETTLE;
          end else begin
            w_state_next = ST_RUN;
          end
        end
      end
      default: begin
        w_state_next = ST_HOLD;
      end
    endcase
  end

  // One-hot decode of the selection that will be applied next cycle.
  assign w_sel_bits_next = w_core_sel_next;
  for (genvar gi = 0; gi < 4; gi++) begin : g_sel_onehot
    assign w_sel_onehot_next[gi] = (w_sel_bits_next == 2'(gi));
  end

  // Output logic, evaluated on the next state so the registered outputs match it.
  always_comb begin
    w_core_rst_n_next = w_sel_onehot_next;
    w_tx_gate_next    = 1'b1;
    w_cts_en_next     = 1'b0;
    w_busy_next       = 1'b1;
    case (w_state_next)
      ST_HOLD: begin
        w_core_rst_n_next = 4'b0000;
      end
      ST_SETTLE: begin
        w_tx_gate_next = 1'b1;
      end
      ST_RUN: begin
        w_tx_gate_next = 1'b0;
        w_cts_en_next  = w_flow_en_next;
        w_busy_next    = 1'b0;
      end
      ST_DRAIN: begin
        w_tx_gate_next = 1'b0;
        w_cts_en_next  = w_flow_en_next;
      end
      default: begin
        w_core_rst_n_next = 4'b0000;
      end
    endcase
  end

  assign o_core_sel   = r_core_sel;
  assign o_core_rst_n = r_core_rst_n;
  assign o_port_sel   = r_port_sel;
  assign o_flow_en    = r_flow_en;
  assign o_tx_gate    = r_tx_gate;
  assign o_cts_en     = r_cts_en;
  assign o_busy       = r_busy;

endmodule

// File: tb/tb_multicomp_core_sequencer.sv
// ---------------------------------------------------------------------------
// tb_multicomp_core_sequencer
// Purpose : Self-checking bench for multicomp_core_sequencer with short timing
//           (RST_HOLD=4, SER_INIT=8, TX_IDLE=5, DRAIN_TIMEOUT=20). A phase /
//           countdown reference model predicts all outputs every cycle.
// ---------------------------------------------------------------------------
module tb_multicomp_core_sequencer;

  localparam int RST_HOLD      = 4;
  localparam int SER_INIT      = 8;
  localparam int TX_IDLE       = 5;
  localparam int DRAIN_TIMEOUT = 20;

  logic       clk_sys = 1'b0;
  logic       reset   = 1'b1;
  logic [1:0] cpu_req = 2'd0;
  logic       port_req = 1'b0;
  logic       flow_req = 1'b0;
  logic       tx_in    = 1'b1;

  logic [1:0] core_sel;
  logic [3:0] core_rst_n;
  logic       port_sel, flow_en, tx_gate, cts_en, busy;

  always #5 clk_sys = ~clk_sys;

  multicomp_core_sequencer #(
    .RST_HOLD      (RST_HOLD),
    .SER_INIT      (SER_INIT),
    .TX_IDLE       (TX_IDLE),
    .DRAIN_TIMEOUT (DRAIN_TIMEOUT)
  ) u_dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .i_cpu_type_req (cpu_req),
    .i_port_sel_req (port_req),
    .i_flow_en_req  (flow_req),
    .i_serial_tx_in (tx_in),
    .o_core_sel     (core_sel),
    .o_core_rst_n   (core_rst_n),
    .o_port_sel     (port_sel),
    .o_flow_en      (flow_en),
    .o_tx_gate      (tx_gate),
    .o_cts_en       (cts_en),
    .o_busy         (busy)
  );

  wire [10:0] dut_vec = {core_sel, core_rst_n, port_sel, flow_en, tx_gate, cts_en, busy};

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // ---------------- reference model: phase + remaining-cycle countdown -------
  typedef enum {P_HOLD, P_SETTLE, P_RUN, P_DRAIN} phase_t;
  phase_t     m_phase = P_HOLD;
  int         m_left  = RST_HOLD;
  logic [1:0] m_sel   = 2'd0;
  logic       m_port  = 1'b0;
  logic       m_flow  = 1'b0;
  int         m_idle  = 0;
  int         m_dlen  = 0;

  function automatic void model_update();
    if (reset) begin
      m_phase = P_HOLD; m_left = RST_HOLD; m_sel = 2'd0; m_port = 1'b0; m_flow = 1'b0;
    end else begin
      case (m_phase)
        P_HOLD: begin
          m_sel = cpu_req; m_port = port_req; m_flow = flow_req;
          m_left--;
          if (m_left == 0) begin m_phase = P_SETTLE; m_left = SER_INIT; end
        end
        P_SETTLE: begin
          m_left--;
          if (m_left == 0) m_phase = P_RUN;
        end
        P_RUN: begin
          if ({cpu_req, port_req, flow_req} != {m_sel, m_port, m_flow}) begin
            m_phase = P_DRAIN; m_idle = 0; m_dlen = 0;
          end
        end
        P_DRAIN: begin
          m_dlen++;
          m_idle = tx_in ? m_idle + 1 : 0;
          if (m_idle >= TX_IDLE || m_dlen >= DRAIN_TIMEOUT) begin
            if (cpu_req != m_sel) begin
              m_phase = P_HOLD; m_left = RST_HOLD;
            end else if ({port_req, flow_req} != {m_port, m_flow}) begin
              m_port = port_req; m_flow = flow_req;
              m_phase = P_SETTLE; m_left = SER_INIT;
            end else begin
              m_phase = P_RUN;
            end
          end
        end
        default: m_phase = P_HOLD;
      endcase
    end
  endfunction

  function automatic logic [10:0] exp_vec();
    logic [3:0] rn;
    logic       gate, cts, bsy;
    rn   = (m_phase == P_HOLD) ? 4'b0000 : (4'b0001 << m_sel);
    gate = (m_phase == P_HOLD) || (m_phase == P_SETTLE);
    cts  = !gate && m_flow;
    bsy  = (m_phase != P_RUN);
    return {m_sel, rn, m_port, m_flow, gate, cts, bsy};
  endfunction

  // One clock: inputs set by the caller are sampled, model advances, then settle.
  task automatic step();
    @(posedge clk_sys);
    model_update();
    cyc++;
    #1;
  endtask

  // ---------------- scenarios ---------------------------------------------
  task automatic test_reset();
    reset = 1'b1; cpu_req = 2'd2; port_req = 1'b0; flow_req = 1'b1; tx_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (dut_vec !== exp_vec()) begin n_errors++; $display("FAIL reset_model cyc=%0d got=%b expected=%b", cyc, dut_vec, exp_vec()); end
      n_checks++;
      if ({core_sel, core_rst_n, port_sel, flow_en, tx_gate, cts_en, busy} !== {2'd0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1}) begin
        n_errors++; $display("FAIL reset_values cyc=%0d got=%b expected=%b", cyc, dut_vec, 11'b00000000101);
      end
    end
  endtask

  task automatic test_reset_release();
    reset = 1'b0;
    for (int i = 1; i < RST_HOLD; i++) begin
      step();
      n_checks++; if (dut_vec !== exp_vec()) begin n_errors++; $display("FAIL release_model cyc=%0d got=%b expected=%b", cyc, dut_vec, exp_vec()); end
      n_checks++; if (core_rst_n !== 4'b0000) begin n_errors++; $display("FAIL release_hold cyc=%0d core_rst_n got=%b expected=0000", cyc, core_rst_n); end
    end
    for (int i = 0; i < SER_INIT; i++) begin
      step();
      n_checks++; if (dut_vec !== exp_vec()) begin n_errors++; $display("FAIL release_model cyc=%0d got=%b expected=%b", cyc, dut_vec, exp_vec()); end
      n_checks++;
      if ({core_rst_n, tx_gate, busy} !== {4'b0100, 1'b1, 1'b1}) begin
        n_errors++; $display("FAIL release_settle cyc=%0d rst_n/gate/busy got=%b %b %b expected=0100 1 1", cyc, core_rst_n, tx_gate, busy);
      end
    end
    step();
    n_checks++; if (dut_vec !== exp_vec()) begin n_errors++; $display("FAIL release_model cyc=%0d got=%b expected=%b", cyc, dut_vec, exp_vec()); end
    n_checks++;
    if ({busy, tx_gate, cts_en, core_sel} !== {1'b0, 1'b0, 1'b1, 2'd2}) begin
      n_errors++; $display("FAIL release_run cyc=%0d busy/gate/cts/sel got=%b %b %b %0d expected=0 0 1 2", cyc, busy, tx_gate, cts_en, core_sel);
    end
  endtask

  task automatic test_core_change();
    int n;
    cpu_req = 2'd0; tx_in = 1'b1;
    step();
    n_checks++; if (dut_vec !== exp_vec()) begin n_errors++; $display("FAIL core_change_model cyc=%0d got=%b expected=%b", cyc, dut_vec, exp_vec()); end
    n = 0;
    while (busy === 1'b1 && tx_gate === 1'b0 && n < 100) begin
      n++; step();
      n_checks++; if (dut_vec !== exp_vec()) begin n_errors++; $display("FAIL core_change_model cyc=%0d got=%b expected=%b", cyc, dut_vec, exp_vec()); end
    end
    n_checks++; if (n !== TX_IDLE) begin n_errors++; $display("FAIL core_change_drain_len got=%0d expected=%0d", n, TX_IDLE); end
    n = 0;
    while (core_rst_n === 4'b0000 && n < 100) begin
      n++; step();
      n_checks++; if (dut_vec !== exp_vec()) begin n_errors++; $display("FAIL core_change_model cyc=%0d got=%b expected=%b", cyc, dut_vec, exp_vec()); end
    end
    n_checks++; if (n !== RST_HOLD) begin n_errors++; $display("FAIL core_change_hold_len got=%0d expected=%0d", n, RST_HOLD); end
    n_checks++;
    if ({core_sel, core_rst_n, tx_gate} !== {2'd0, 4'b0001, 1'b1}) begin
      n_errors++; $display("FAIL core_change_settle_entry sel/rst_n/gate got=%0d %b %b expected=0 0001 1", core_sel, core_rst_n, tx_gate);
    end
    n = 0;
    while (core_rst_n === 4'b0001 && tx_gate === 1'b1 && n < 100) begin
      n++; step();
      n_checks++; if (dut_vec !== exp_vec()) begin n_errors++; $display("FAIL core_change_model cyc=%0d got=%b expected=%b", cyc, dut_vec, exp_vec()); end
    end
    n_checks++; if (n !== SER_INIT) begin n_errors++; $display("FAIL core_change_settle_len got=%0d expected=%0d", n, SER_INIT); end
  endtask

  task automatic test_port_busy_line();
    int n;
    int k;
    port_req = 1'b1; tx_in = 1'b1; k = 0;
    step();
    n_checks++; if (dut_vec !== exp_vec()) begin n_errors++; $display("FAIL port_busy_model cyc=%0d got=%b expected=%b", cyc, dut_vec, exp_vec()); end
    n = 0;
    while (busy === 1'b1 && tx_gate === 1'b0 && n < 100) begin
      n++;
      k++;
      tx_in = (k % 3 != 0);
      step();
      n_checks++; if (dut_vec !== exp_vec()) begin n_errors++; $display("FAIL port_busy_model cyc=%0d got=%b expected=%b", cyc, dut_vec, exp_vec()); end
      n_checks++; if (!$onehot(core_rst_n)) begin n_errors++; $display("FAIL port_busy_onehot cyc=%0d core_rst_n got=%b expected=one-hot", cyc, core_rst_n); end
    end
    n_checks++; if (n !== DRAIN_TIMEOUT) begin n_errors++; $display("FAIL port_busy_drain_len got=%0d expected=%0d", n, DRAIN_TIMEOUT); end
    n_checks++;
    if ({busy, tx_gate, core_rst_n, port_sel} !== {1'b1, 1'b1, 4'b0001, 1'b1}) begin
      n_errors++; $display("FAIL port_busy_settle busy/gate/rst_n/port got=%b %b %b %b expected=1 1 0001 1", busy, tx_gate, core_rst_n, port_sel);
    end
    tx_in = 1'b1;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++; step();
      n_checks++; if (dut_vec !== exp_vec()) begin n_errors++; $display("FAIL port_busy_model cyc=%0d got=%b expected=%b", cyc, dut_vec, exp_vec()); end
    end
  endtask

  task automatic test_reverted_request();
    int n;
    cpu_req = 2'd3; tx_in = 1'b1;
    step();
    n_checks++; if (dut_vec !== exp_vec()) begin n_errors++; $display("FAIL revert_model cyc=%0d got=%b expected=%b", cyc, dut_vec, exp_vec()); end
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      if (n == 2) cpu_req = 2'd0;
      step();
      n_checks++; if (dut_vec !== exp_vec()) begin n_errors++; $display("FAIL revert_model cyc=%0d got=%b expected=%b", cyc, dut_vec, exp_vec()); end
      n_checks++;
      if ({core_sel, core_rst_n, port_sel, flow_en, tx_gate, cts_en} !== {2'd0, 4'b0001, 1'b1, 1'b1, 1'b0, 1'b1}) begin
        n_errors++; $display("FAIL revert_outputs cyc=%0d got=%b expected=0000011101x", cyc, dut_vec);
      end
    end
    n_checks++; if (n !== TX_IDLE) begin n_errors++; $display("FAIL revert_drain_len got=%0d expected=%0d", n, TX_IDLE); end
  endtask

  task automatic test_reset_mid_settle();
    int n;
    port_req = 1'b0; tx_in = 1'b1;
    n = 0;
    while (tx_gate !== 1'b1 && n < 100) begin
      n++; step();
      n_checks++; if (dut_vec !== exp_vec()) begin n_errors++; $display("FAIL mid_settle_model cyc=%0d got=%b expected=%b", cyc, dut_vec, exp_vec()); end
    end
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (dut_vec !== exp_vec()) begin n_errors++; $display("FAIL mid_settle_model cyc=%0d got=%b expected=%b", cyc, dut_vec, exp_vec()); end
    end
    reset = 1'b1;
    step();
    n_checks++;
    if ({core_sel, core_rst_n, port_sel, flow_en, tx_gate, cts_en, busy} !== {2'd0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1}) begin
      n_errors++; $display("FAIL mid_settle_reset cyc=%0d got=%b expected=00000000101", cyc, dut_vec);
    end
    reset = 1'b0;
    n = 0;
    while (core_rst_n === 4'b0000 && n < 100) begin
      n++; step();
      n_checks++; if (dut_vec !== exp_vec()) begin n_errors++; $display("FAIL mid_settle_model cyc=%0d got=%b expected=%b", cyc, dut_vec, exp_vec()); end
    end
    n_checks++; if (n !== RST_HOLD) begin n_errors++; $display("FAIL mid_settle_hold_len got=%0d expected=%0d", n, RST_HOLD); end
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++; step();
      n_checks++; if (dut_vec !== exp_vec()) begin n_errors++; $display("FAIL mid_settle_model cyc=%0d got=%b expected=%b", cyc, dut_vec, exp_vec()); end
    end
  endtask

  task automatic test_requests_hold_settle();
    int n;
    reset = 1'b1; tx_in = 1'b1;
    step();
    reset = 1'b0; cpu_req = 2'd3;
    step();
    n_checks++; if (core_sel !== 2'd3) begin n_errors++; $display("FAIL hold_track_a core_sel got=%0d expected=3", core_sel); end
    cpu_req = 2'd1;
    step();
    n_checks++; if (core_sel !== 2'd1) begin n_errors++; $display("FAIL hold_track_b core_sel got=%0d expected=1", core_sel); end
    cpu_req = 2'd3;
    n = 0;
    while (core_rst_n === 4'b0000 && n < 100) begin
      n++; step();
      n_checks++; if (dut_vec !== exp_vec()) begin n_errors++; $display("FAIL hold_settle_model cyc=%0d got=%b expected=%b", cyc, dut_vec, exp_vec()); end
    end
    n_checks++;
    if ({core_sel, core_rst_n} !== {2'd3, 4'b1000}) begin
      n_errors++; $display("FAIL hold_settle_entry sel/rst_n got=%0d %b expected=3 1000", core_sel, core_rst_n);
    end
    step();
    cpu_req = 2'd2;
    n = 0;
    while (tx_gate === 1'b1 && n < 100) begin
      n++; step();
      n_checks++; if (core_sel !== 2'd3) begin n_errors++; $display("FAIL settle_deferred cyc=%0d core_sel got=%0d expected=3", cyc, core_sel); end
    end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL settle_first_run busy got=%b expected=0", busy); end
    step();
    n_checks++;
    if ({busy, tx_gate} !== {1'b1, 1'b0}) begin
      n_errors++; $display("FAIL settle_second_run_drain busy/gate got=%b %b expected=1 0", busy, tx_gate);
    end
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++; step();
      n_checks++; if (dut_vec !== exp_vec()) begin n_errors++; $display("FAIL hold_settle_model cyc=%0d got=%b expected=%b", cyc, dut_vec, exp_vec()); end
    end
  endtask

  task automatic test_random();
    logic [1:0] prev_sel;
    logic [3:0] prev_rn;
    for (int i = 0; i < 800; i++) begin
      prev_sel = core_sel;
      prev_rn  = core_rst_n;
      reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 29) == 0) cpu_req = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) port_req = ~port_req;
      if ($urandom_range(0, 39) == 0) flow_req = ~flow_req;
      tx_in = ($urandom_range(0, 5) != 0);
      step();
      n_checks++; if (dut_vec !== exp_vec()) begin n_errors++; $display("FAIL random_model cyc=%0d got=%b expected=%b", cyc, dut_vec, exp_vec()); end
      n_checks++; if (!$onehot0(core_rst_n)) begin n_errors++; $display("FAIL random_onehot cyc=%0d core_rst_n got=%b expected=one-hot-or-zero", cyc, core_rst_n); end
      n_checks++;
      if (!reset && core_sel !== prev_sel && prev_rn !== 4'b0000) begin
        n_errors++; $display("FAIL random_sel_change cyc=%0d core_sel %0d->%0d while core_rst_n=%b expected=0000", cyc, prev_sel, core_sel, prev_rn);
      end
    end
  endtask

  initial begin
    test_reset();
    test_reset_release();
    test_core_change();
    test_port_busy_line();
    test_reverted_request();
    test_reset_mid_settle();
    test_requests_hold_settle();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/multicomp_core_sequencer.md
# multicomp_core_sequencer

Sequences safe switching of the active computer core and serial-port configuration in the MultiComp top level. It owns the core select, the per-core reset enables, the applied serial port/flow-control settings, TX mark gating and CTS enable. On a change request it drains the serial line, holds all cores in reset where needed, and releases the selected core. It then holds off flow control for an init window. It sits between the OSD status bits and the core/serial muxes.

## Interface
- `RST_HOLD`, 1024: cycles all cores are held in reset in HOLD.
- `SER_INIT`, 50000: cycles of TX gating and CTS hold-off after release (1 ms at 50 MHz).
- `TX_IDLE`, 230000: consecutive TX-high cycles that count as line idle (≥1 char at 2400 baud).
- `DRAIN_TIMEOUT`, 5000000: maximum DRAIN duration in cycles.
- `clk_sys`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `cpu_type_req`  in  2  requested core: 0 Z80-CP/M, 1 Z80-BASIC, 2 6502, 3 6809.
- `port_sel_req`  in  1  requested port: 0 console UART, 1 user IO.
- `flow_en_req`  in  1  requested RTS/CTS enable.
- `serial_tx_in`  in  1  TXD of the currently selected core.
- `core_sel`  out  2  applied core select.
- `core_rst_n`  out  4  per-core run enable, one-hot or zero.
- `port_sel`  out  1  applied port select.
- `flow_en`  out  1  applied flow-control enable.
- `tx_gate`  out  1  1 forces TXD/RTS to mark/deasserted.
- `cts_en`  out  1  CTS path enable.
- `busy`  out  1  high in every state except RUN.

## Operation
- **Reset values:** state=HOLD, all counters 0, `core_sel`=0, `port_sel`=0, `flow_en`=0, `core_rst_n`=0000, `tx_gate`=1, `cts_en`=0, `busy`=1.
- **HOLD**
  - Outputs: `core_rst_n`=0000, `tx_gate`=1, `cts_en`=0.
  - `core_sel`, `port_sel` and `flow_en` are loaded from the requests every cycle.
  - After RST_HOLD cycles, go to SETTLE.
- **SETTLE**
  - Outputs: `core_rst_n`=onehot(`core_sel`), `tx_gate`=1, `cts_en`=0.
  - Requests are ignored.
  - After SER_INIT cycles, go to RUN.
- **RUN**
  - Outputs: `core_rst_n`=onehot(`core_sel`), `tx_gate`=0, `cts_en`=`flow_en`, `busy`=0.
  - If any request differs from its applied value, go to DRAIN.
- **DRAIN**
  - Outputs are the same as RUN except `busy`=1.
  - The idle counter increments while `serial_tx_in`=1 and clears to 0 when `serial_tx_in`=0.
  - The timeout counter increments every cycle.
  - Exit when the idle count reaches TX_IDLE or the timeout count reaches DRAIN_TIMEOUT; requests are evaluated at exit, not at entry.
  - Exit to HOLD if `cpu_type_req`≠`core_sel`.
  - Otherwise, if the port or flow request differs, load `port_sel`/`flow_en` and go to SETTLE; the core stays out of reset.
  - Otherwise (the request was reverted), return to RUN with nothing changed.
- **Priority:** `reset` overrides every state.

## Timing
- All outputs are registered; a state change is visible one cycle after the decision.
- HOLD lasts exactly RST_HOLD cycles, counted from the first cycle with `reset` low, or from the entry cycle.
- SETTLE lasts exactly SER_INIT cycles.
- DRAIN lasts between TX_IDLE and DRAIN_TIMEOUT cycles, inclusive.
- **Reset mid-operation:** HOLD is entered on the next cycle with counters cleared and outputs at their reset values.
- **Request during SETTLE:** the change is seen in the first RUN cycle, which enters DRAIN on the following cycle.
- **Simultaneous idle and timeout at DRAIN exit:** a single exit occurs; the exit branch is chosen as above.
- **Counters:** width is $clog2(max parameter + 1); counters saturate and never wrap.
- **Invariant:** `core_rst_n` is never multi-hot, and `core_sel` changes only while `core_rst_n`=0000.

## Structure
- Package `multicomp_pkg` holds:
  - `cpu_type_e`, with the encodings listed above;
  - `seq_state_e` {HOLD, SETTLE, RUN, DRAIN};
  - the default timing constants.
- One sub-module, `tx_idle_detector`, contains the idle counter, the drain timeout counter and the `drain_done` output.
- The top-level MultiComp replaces its init counter and direct `status` decoding with this block's outputs.

## Test plan
All scenarios use RST_HOLD=4, SER_INIT=8, TX_IDLE=5, DRAIN_TIMEOUT=20.
- **Reset release:** release `reset` with `cpu_type_req`=2 and `flow_en_req`=1.
  - `core_rst_n`=0000 for 4 cycles, then 0100 with `tx_gate`=1 for 8 cycles.
  - Then RUN: `busy`=0, `tx_gate`=0, `cts_en`=1.
- **Core change, idle line:** in RUN, change `cpu_type_req` 2→0 with `serial_tx_in`=1.
  - DRAIN lasts 5 cycles, then HOLD with 0000 for 4 cycles and `core_sel`=0.
  - Then SETTLE with 0001 for 8 cycles.
- **Port change, busy line:** toggle `port_sel_req` while `serial_tx_in` pulses low every 3 cycles.
  - DRAIN exits on the 20-cycle timeout and goes to SETTLE.
  - `core_rst_n` stays one-hot throughout.
- **Reverted request:** revert `cpu_type_req` back to its applied value during DRAIN.
  - Return to RUN with no reset and no output change except `busy`.
- **Reset mid-SETTLE:** assert `reset` mid-SETTLE.
  - The next cycle is HOLD, with `core_rst_n`=0000 and the hold count restarting at 0.
- **Requests during HOLD and SETTLE:**
  - A `cpu_type_req` change during HOLD is tracked into `core_sel`.
  - A change during SETTLE is deferred: DRAIN is entered on the second RUN cycle.
